// File: rtl/melody_sequencer.sv
// Plays a fixed 16-step melody on the 12-bit freq bus. Each step is a note followed by a silent gap.
// All outputs are registered: a start pulse shows up on the outputs one cycle later, and the block has no backpressure.
module melody_sequencer #(
  parameter int BEAT_DIV   = 25_000_000,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [11:0] freq,
  output logic [3:0]  step_idx,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(4 * BEAT_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [3:0]    stepNext;
  logic [11:0]   freqNext;
  logic          busyNext, doneNext;
  logic [1:0]    curBeats;
  logic [CW-1:0] stepLast, noteLast;

  function automatic logic [11:0] songHz(input logic [3:0] idx);
    logic [11:0] hz;
    case (idx)
      4'd0:    hz = 12'd262;
      4'd1:    hz = 12'd294;
      4'd2:    hz = 12'd330;
      4'd3:    hz = 12'd349;
      4'd4:    hz = 12'd392;
      4'd5:    hz = 12'd440;
      4'd6:    hz = 12'd494;
      4'd7:    hz = 12'd523;
      4'd8:    hz = 12'd523;
      4'd9:    hz = 12'd494;
      4'd10:   hz = 12'd440;
      4'd11:   hz = 12'd392;
      4'd12:   hz = 12'd349;
      4'd13:   hz = 12'd330;
      4'd14:   hz = 12'd294;
      default: hz = 12'd262;
    endcase
    return hz;
  endfunction

  // Stored as beats-1, so step 15 (4 beats) encodes as 3.
  function automatic logic [1:0] songBeats(input logic [3:0] idx);
    logic [1:0] b;
    case (idx)
      4'd7:    b = 2'd1;
      4'd15:   b = 2'd3;
      default: b = 2'd0;
    endcase
    return b;
  endfunction

  // One counter spans the whole step, note plus gap. Note onsets therefore stay exactly D cycles apart.
  always_comb begin
    curBeats = songBeats(step_idx);
    stepLast = CW'((int'(curBeats) + 1) * BEAT_DIV - 1);
    noteLast = CW'((int'(curBeats) + 1) * BEAT_DIV - GAP_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      step_idx <= '0;
      freq     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      step_idx <= stepNext;
      freq     <= freqNext;
      busy     <= busyNext;
      done     <= doneNext;
    end
  end

  always_comb begin
    stateNext = state;
    stepNext  = step_idx;
    cntNext   = cnt;
    doneNext  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = NOTE;
          stepNext  = 4'd0;
          cntNext   = '0;
        end
      end
      NOTE: begin
        cntNext = cnt + 1'b1;
        if (cnt == noteLast) begin
          stateNext = GAP;
        end
      end
      GAP: begin
        if (cnt == stepLast) begin
          cntNext = '0;
          if (step_idx != 4'd15) begin
            stateNext = NOTE;
            stepNext  = step_idx + 4'd1;
          end else if (loop_en) begin
            stateNext = NOTE;
            stepNext  = 4'd0;
          end else begin
            stateNext = IDLE;
            stepNext  = 4'd0;
            doneNext  = 1'b1;
          end
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        stepNext  = 4'd0;
        cntNext   = '0;
      end
    endcase

    // Stop overrides start and sequencing. In IDLE it just holds the idle values.
    if (stop) begin
      stateNext = IDLE;
      stepNext  = 4'd0;
      cntNext   = '0;
      doneNext  = 1'b0;
    end

    freqNext = (stateNext == NOTE) ? songHz(stepNext) : 12'd0;
    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Checks melody_sequencer with BEAT_DIV=4 and GAP_CYCLES=1 against a song-position model.
// Literal spot checks along the way pin the model itself.
module tb_melody_sequencer;

  localparam int BD = 4;
  localparam int GC = 1;
  localparam int SONG_LEN = 80;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en;
  logic [11:0] freq;
  logic [3:0]  step_idx;
  logic        busy, done;

  melody_sequencer #(.BEAT_DIV(BD), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .freq(freq), .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int view  = 0;

  int songHzT[16]    = '{262, 294, 330, 349, 392, 440, 494, 523,
                         523, 494, 440, 392, 349, 330, 294, 262};
  int songBeatsT[16] = '{1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 4};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Position in the song (0..79) maps to a step and a frequency. The last cycle of each step is the gap.
  task automatic songAt(input int pos, output int f, output int s);
    int base;
    base = 0;
    f = 0;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      int dur;
      dur = songBeatsT[i] * BD;
      if (pos >= base && pos < base + dur) begin
        s = i;
        f = (pos - base < dur - GC) ? songHzT[i] : 0;
      end
      base += dur;
    end
  endtask

  bit mValid  = 1'b0;
  bit mActive = 1'b0;
  bit mDone   = 1'b0;
  int mPos    = 0;

  always @(posedge clk) begin
    mDone = 1'b0;
    if (rst) mActive = 1'b0;
    else if (stop) mActive = 1'b0;
    else if (!mActive) begin
      if (start) begin
        mActive = 1'b1;
        mPos = 0;
      end
    end else if (mPos == SONG_LEN - 1) begin
      if (loop_en) mPos = 0;
      else begin
        mActive = 1'b0;
        mDone = 1'b1;
      end
    end else mPos++;
    mValid = 1'b1;
  end

  always @(negedge clk) begin : compare
    int ef, es;
    if (mValid) begin
      if (mActive) songAt(mPos, ef, es);
      else begin
        ef = 0;
        es = 0;
      end
      chk("model_freq", int'(freq), ef);
      chk("model_step", int'(step_idx), es);
      chk("model_busy", int'(busy), int'(mActive));
      chk("model_done", int'(done), int'(mDone));
    end
  end

  task automatic goTo(input int target);
    while (view < target) begin
      @(negedge clk);
      view++;
    end
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    view = 1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_freq", int'(freq), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_step", int'(step_idx), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single run, with a start pulse during step 5 that must be ignored.
    startPulse();
    chk("t1_freq", int'(freq), 262);
    chk("t1_busy", int'(busy), 1);
    goTo(4);  chk("t4_freq", int'(freq), 0);
    goTo(5);  chk("t5_freq", int'(freq), 294);
    chk("t5_step", int'(step_idx), 1);
    goTo(22); start = 1'b1;
    goTo(23); start = 1'b0;
    goTo(29); chk("s7_first", int'(freq), 523);
    goTo(35); chk("s7_last", int'(freq), 523);
    goTo(36); chk("s7_gap", int'(freq), 0);
    chk("s7_gapstep", int'(step_idx), 7);
    goTo(65); chk("s15_first", int'(freq), 262);
    goTo(79); chk("s15_last", int'(freq), 262);
    goTo(80); chk("s15_gap", int'(freq), 0);
    chk("s15_busy", int'(busy), 1);
    goTo(81); chk("end_done", int'(done), 1);
    chk("end_busy", int'(busy), 0);
    goTo(82); chk("end_done_clr", int'(done), 0);

    // Looping run, stopped during step 3 of the second pass.
    goTo(85);
    loop_en = 1'b1;
    startPulse();
    goTo(81); chk("loop_freq", int'(freq), 262);
    chk("loop_step", int'(step_idx), 0);
    chk("loop_busy", int'(busy), 1);
    chk("loop_done", int'(done), 0);
    goTo(94); stop = 1'b1;
    goTo(95); stop = 1'b0;
    chk("stop_freq", int'(freq), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);

    // When start and stop arrive together, stop wins. A stop while idle does nothing.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    @(negedge clk);
    chk("ss_busy2", int'(busy), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_busy", int'(busy), 0);

    // loop_en is only sampled at the end of step 15, so clearing it mid-run ends the song.
    loop_en = 1'b1;
    startPulse();
    goTo(60); loop_en = 1'b0;
    goTo(81); chk("lat_done", int'(done), 1);
    chk("lat_busy", int'(busy), 0);

    // Reset asserted mid-melody.
    goTo(84);
    startPulse();
    goTo(10); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_freq", int'(freq), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_step", int'(step_idx), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
